// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state types and burst address helpers for the
// AXI memory slave (axi_mem_slave, axi_mem_array, axi_mem_slave_if).
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    // Beat size requests wider than the bus are treated as full-width beats.
    function automatic logic [2:0] eff_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

    // INCR burst: each beat advances the byte address by the (clamped) beat size.
    function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                   input logic [2:0]  size,
                                                   input logic [2:0]  max_size);
        return addr + (64'd1 << eff_size(size, max_size));
    endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI3-style bus bundle (AW/W/B/AR/R) between a master and axi_mem_slave.
interface axi_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [LEN_W-1:0]    arlen;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awvalid, output awready,
        input wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_mem_array.sv
// DEPTH x DATA_W storage: one byte-enabled write port, one registered read port.
module axi_mem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_re,
    input  logic [IDX_W-1:0]    i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_p1;

    // Byte-lane write: only lanes with a set strobe bit are updated.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; a same-cycle write to the same word is seen next time, so old data is returned.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata_p1 <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI memory slave with independent write and read FSMs over axi_mem_array.
// INCR bursts only; beat sizes wider than the bus are clamped to full width.
// Optional macro AXI_MEM_OOR_ERR_EN: word indices >= DEPTH are flagged SLVERR
// (writes dropped, reads return zero) instead of wrapping modulo DEPTH.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 1024
) (
    input logic             clk,
    input logic             reset,
    axi_mem_slave_if.slave  s_axi
);

    localparam int              STRB_W   = DATA_W / 8;
    localparam int              OFF_W    = $clog2(STRB_W);
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]      MAX_SIZE = 3'(OFF_W);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    // Byte address to full (unwrapped) word index.
    function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return a >> OFF_W;
    endfunction

    // Word index folded into the array.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] w);
        return IDX_W'(w % DEPTH_A);
    endfunction

    // Write channel state
    w_state_t          r_w_state, w_w_next;
    logic [ID_W-1:0]   r_awid;
    logic [ADDR_W-1:0] r_awaddr;
    logic [LEN_W-1:0]  r_awlen;
    logic [2:0]        r_awsize;
    logic [LEN_W-1:0]  r_wcnt;
    logic              r_berr;

    // Read channel state
    r_state_t          r_r_state, w_r_next;
    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [LEN_W-1:0]  r_arlen;
    logic [2:0]        r_arsize;
    logic [LEN_W-1:0]  r_rcnt;
    logic              r_rd_oor_p1;

    logic              w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic              w_beat_last, w_beat_err, w_wr_oor, w_rd_oor, w_rlast;
    logic [ADDR_W-1:0] w_aw_next, w_ar_next;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_aw_hs     = (r_w_state == W_IDLE) && !reset && s_axi.awvalid;
    assign w_w_hs      = (r_w_state == W_DATA) && s_axi.wvalid;
    assign w_ar_hs     = (r_r_state == R_IDLE) && !reset && s_axi.arvalid;
    assign w_r_hs      = (r_r_state == R_DATA) && s_axi.rready;
    assign w_beat_last = (r_wcnt == r_awlen);
    assign w_rlast     = (r_rcnt == r_arlen);
    assign w_aw_next   = ADDR_W'(next_beat_addr(64'(r_awaddr), r_awsize, MAX_SIZE));
    assign w_ar_next   = ADDR_W'(next_beat_addr(64'(r_araddr), r_arsize, MAX_SIZE));

`ifdef AXI_MEM_OOR_ERR_EN
    assign w_wr_oor = (word_of(r_awaddr) >= DEPTH_A);
    assign w_rd_oor = (word_of(r_araddr) >= DEPTH_A);
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    // Burst ends on beat count alone; misplaced/missing wlast, wrong wid or range error poison the response.
    assign w_beat_err = (s_axi.wlast != w_beat_last) || (s_axi.wid != r_awid) || w_wr_oor;

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_w_state <= W_IDLE;
        else       r_w_state <= w_w_next;
    end

    // Write FSM next state and handshake outputs
    always_comb begin
        w_w_next      = r_w_state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bresp   = RESP_OKAY;
        s_axi.bid     = r_awid;
        case (r_w_state)
            W_IDLE: begin
                s_axi.awready = !reset;
                if (w_aw_hs) w_w_next = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (w_w_hs && w_beat_last) w_w_next = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bresp  = r_berr ? RESP_SLVERR : RESP_OKAY;
                if (s_axi.bready) w_w_next = W_IDLE;
            end
            default: w_w_next = W_IDLE;
        endcase
    end

    // Write control: captured id, beat counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_awid <= '0;
            r_wcnt <= '0;
            r_berr <= 1'b0;
        end else if (w_aw_hs) begin
            r_awid <= s_axi.awid;
            r_wcnt <= '0;
            r_berr <= 1'b0;
        end else if (w_w_hs) begin
            r_wcnt <= r_wcnt + 1'b1;
            r_berr <= r_berr | w_beat_err;
        end
    end

    // Write datapath: burst address, length and size
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_awaddr <= s_axi.awaddr;
            r_awlen  <= s_axi.awlen;
            r_awsize <= s_axi.awsize;
        end else if (w_w_hs) begin
            r_awaddr <= w_aw_next;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_r_state <= R_IDLE;
        else       r_r_state <= w_r_next;
    end

    // Read FSM next state and R-channel outputs
    always_comb begin
        w_r_next      = r_r_state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        s_axi.rlast   = 1'b0;
        s_axi.rresp   = RESP_OKAY;
        s_axi.rdata   = '0;
        s_axi.rid     = r_arid;
        case (r_r_state)
            R_IDLE: begin
                s_axi.arready = !reset;
                if (w_ar_hs) w_r_next = R_FETCH;
            end
            R_FETCH: begin
                w_r_next = R_DATA;
            end
            R_DATA: begin
                s_axi.rvalid = 1'b1;
                s_axi.rlast  = w_rlast;
                s_axi.rresp  = r_rd_oor_p1 ? RESP_SLVERR : RESP_OKAY;
                s_axi.rdata  = r_rd_oor_p1 ? '0 : w_mem_rdata;
                if (w_r_hs) w_r_next = w_rlast ? R_IDLE : R_FETCH;
            end
            default: w_r_next = R_IDLE;
        endcase
    end

    // Read control: captured id, beat counter, range flag of the fetched beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arid      <= '0;
            r_rcnt      <= '0;
            r_rd_oor_p1 <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_arid <= s_axi.arid;
                r_rcnt <= '0;
            end else if (w_r_hs) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
            if (r_r_state == R_FETCH) r_rd_oor_p1 <= w_rd_oor;
        end
    end

    // Read datapath: burst address, length and size
    always_ff @(posedge clk) begin
        if (w_ar_hs) begin
            r_araddr <= s_axi.araddr;
            r_arlen  <= s_axi.arlen;
            r_arsize <= s_axi.arsize;
        end else if (w_r_hs) begin
            r_araddr <= w_ar_next;
        end
    end

    axi_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_w_hs && !w_wr_oor),
        .i_waddr (wrap_idx(word_of(r_awaddr))),
        .i_wdata (s_axi.wdata),
        .i_wstrb (s_axi.wstrb),
        .i_re    (r_r_state == R_FETCH),
        .i_raddr (wrap_idx(word_of(r_araddr))),
        .o_rdata (w_mem_rdata)
    );

endmodule
